alu_decode_stage: RTL
=====================

# alu_decode_stage

Registered, flow-controlled ALU decode stage that replaces the purely combinational decoder in the control path. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes it into ALU op, form, vector/carry controls, constant and register selects. A register scoreboard tracks outstanding destination writes and stalls any instruction that reads a pending register. It sits between instruction fetch and the ALU issue/register-read stage.

## Interface
- `SEL_W`, 4: register-select width; register file has 2^SEL_W entries, index 0 = "none".
- `DATA_W`, 32: constant output width (≥18).
- `CNT_W`, 8: invalid-instruction counter width.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: stage accepts instruction this cycle.
- `instruction` in 32: encoded instruction.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: downstream accepts bundle.
- `alu_op` out 3; `alu_form` out 1; `alu_vec_perci` out 2; `const_c` out 1.
- `constant` out DATA_W: zero-extended immediate.
- `zero_reg` out SEL_W: register forced to zero.
- `alu_a_select`, `alu_b_select`, `alu_c_select`, `alu_d_select` out SEL_W each.
- `alu_y1_select`, `alu_y2_select` out SEL_W each.
- `alu_write` out 2: write enables for Y1/Y2.
- `wb_valid` in 2: writeback retire strobes for two ports.
- `wb_reg0`, `wb_reg1` in SEL_W: registers being retired.
- `err_invalid` out 1: one-cycle pulse on invalid instruction accepted.
- `invalid_count` out CNT_W: saturating count of invalid instructions.

## Operation
- Fields: `const_c`=[28], `alu_op`=[27:25], `alu_form`=[24], `alu_vec_perci`=[23:22], imm_hi=[21:16], selects a/b/c/d = consecutive SEL_W slices from bit 0 upward, d at LSB (SEL_W=4 gives [15:12],[11:8],[7:4],[3:0]).
- Y1 = a select, Y2 = c select.
- Register form (`const_c`=0, either `alu_form`): sources a,b,c,d; `alu_write[0]`=(Y1≠0), `alu_write[1]`=(Y2≠0); `constant`=0, `zero_reg`=0.
- Constant form (`alu_form`=0, `const_c`=1): `constant`={zeros, imm_hi, instruction[11:0]}; `zero_reg`=4'b1010 zero-extended to SEL_W; `alu_write`=2'b01; only source is a.
- Invalid (`alu_form`=1, `const_c`=1): consumed when accepted, never issued (`out_valid` unchanged); `err_invalid` pulses; `invalid_count` increments, saturating at all-ones.
- Hazard: any active source ≠0 with pending bit set and not retired this cycle → `in_ready`=0. WAW on Y1/Y2 destinations also stalls.
- Issue: on accept of a valid instruction, set pending bits for Y1/Y2 where `alu_write` bit set.
- Retire: `wb_valid[i]` clears pending[`wb_regi`]; index 0 ignored. Same-cycle retire and issue-set of same reg → set wins.
- `in_ready` = (!`out_valid` | `out_ready`) & !hazard. Invalid instructions bypass the hazard check and need only the output-space term.

## Timing
- Latency 1 cycle: accepted instruction appears on outputs next cycle with `out_valid`=1.
- Full throughput: back-to-back independent instructions, one per cycle, when `out_ready`=1.
- Output register holds stable while `out_valid`=1 & `out_ready`=0.
- Stalled instruction held by upstream; no internal skid storage.
- Reset: all outputs 0, pending bits all 0, `invalid_count`=0, `in_ready`=1 the cycle after reset deasserts. Reset mid-stall discards the held bundle and all pending state.

## Configuration
- `ALU_DEC_SCOREBOARD_EN` defined: scoreboard, hazard stall and `wb_*` retire logic present as above.
- Not defined: no pending state; hazard term constant 0; `wb_*` inputs ignored; `in_ready` = !`out_valid` | `out_ready`.

## Test plan
- Reset, then constant-form 0x10_3F_0ABC with `out_ready`=1 → next cycle `out_valid`=1, `constant`=0x3FABC, `zero_reg`=0xA, `alu_write`=01, a select=0.
- Register form with a=3, c=5, then instruction reading b=3 → second stalls (`in_ready`=0) until `wb_valid[0]`=1, `wb_reg0`=3; accepted same cycle as retire.
- Invalid (bits 28 and 24 set) → `err_invalid` one-cycle pulse, `invalid_count` 0→1, `out_valid` stays 0; 256 invalids → count saturates at 255.
- `out_ready`=0 for 3 cycles with bundle held → outputs stable, `in_ready`=0; release → next instruction accepted.
- Issue writing Y1=7 while `wb_valid[1]` retires reg 7 same cycle → pending[7]=1 afterwards; reader of 7 stalls.
- Build without `ALU_DEC_SCOREBOARD_EN`: dependent pair a=3 then b=3 issues back-to-back, no stall.

Source files
------------

// File: rtl/alu_decode_stage_if.sv
// Instruction-in / decoded-bundle-out / writeback-retire signals of the ALU decode stage.
// slave = the decode stage itself, master = the surrounding fetch/issue environment.
interface alu_decode_stage_if #(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        alu_op;
  logic              alu_form;
  logic [1:0]        alu_vec_perci;
  logic              const_c;
  logic [DATA_W-1:0] constant;
  logic [SEL_W-1:0]  zero_reg;
  logic [SEL_W-1:0]  alu_a_select;
  logic [SEL_W-1:0]  alu_b_select;
  logic [SEL_W-1:0]  alu_c_select;
  logic [SEL_W-1:0]  alu_d_select;
  logic [SEL_W-1:0]  alu_y1_select;
  logic [SEL_W-1:0]  alu_y2_select;
  logic [1:0]        alu_write;
  logic [1:0]        wb_valid;
  logic [SEL_W-1:0]  wb_reg0;
  logic [SEL_W-1:0]  wb_reg1;
  logic              err_invalid;
  logic [CNT_W-1:0]  invalid_count;

  modport slave (
    input  in_valid, instruction, out_ready, wb_valid, wb_reg0, wb_reg1,
    output in_ready, out_valid, alu_op, alu_form, alu_vec_perci, const_c, constant, zero_reg,
           alu_a_select, alu_b_select, alu_c_select, alu_d_select, alu_y1_select, alu_y2_select,
           alu_write, err_invalid, invalid_count
  );

  modport master (
    output in_valid, instruction, out_ready, wb_valid, wb_reg0, wb_reg1,
    input  in_ready, out_valid, alu_op, alu_form, alu_vec_perci, const_c, constant, zero_reg,
           alu_a_select, alu_b_select, alu_c_select, alu_d_select, alu_y1_select, alu_y2_select,
           alu_write, err_invalid, invalid_count
  );
endinterface

// File: rtl/alu_decode_stage.sv
// ALU decode stage, 1-cycle latency; in_ready drops while the output register is held or, with
// ALU_DEC_SCOREBOARD_EN defined, while a source/destination register has a pending write.
module alu_decode_stage #(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_decode_stage_if.slave bus
);
  localparam int NREG = 1 << SEL_W;

  typedef struct packed {
    logic [2:0]        op;
    logic              form;
    logic [1:0]        perci;
    logic              const_c;
    logic [DATA_W-1:0] constant;
    logic [SEL_W-1:0]  zero_reg;
    logic [SEL_W-1:0]  a_sel;
    logic [SEL_W-1:0]  b_sel;
    logic [SEL_W-1:0]  c_sel;
    logic [SEL_W-1:0]  d_sel;
    logic [SEL_W-1:0]  y1_sel;
    logic [SEL_W-1:0]  y2_sel;
    logic [1:0]        write;
  } bundle_t;

  bundle_t          dec, bundle_q, bundle_d;
  logic             out_valid_q, out_valid_d;
  logic             err_invalid_q, err_invalid_d;
  logic [CNT_W-1:0] invalid_count_q, invalid_count_d;
  logic             is_const, is_invalid, hazard, accept, issue;
  logic             unused_bits;

  assign unused_bits = ^bus.instruction[31:29];

  always_comb begin
    is_const   = bus.instruction[28] & ~bus.instruction[24];
    is_invalid = bus.instruction[28] & bus.instruction[24];
    dec         = '0;
    dec.op      = bus.instruction[27:25];
    dec.form    = bus.instruction[24];
    dec.perci   = bus.instruction[23:22];
    dec.const_c = bus.instruction[28];
    dec.a_sel   = bus.instruction[4*SEL_W-1 -: SEL_W];
    dec.y1_sel  = dec.a_sel;
    if (is_const) begin
      // b/c/d bit positions carry the low immediate here, so those selects stay 0
      dec.constant = DATA_W'({bus.instruction[21:16], bus.instruction[11:0]});
      dec.zero_reg = SEL_W'(4'b1010);
      dec.write    = 2'b01;
    end else begin
      dec.b_sel  = bus.instruction[3*SEL_W-1 -: SEL_W];
      dec.c_sel  = bus.instruction[2*SEL_W-1 -: SEL_W];
      dec.d_sel  = bus.instruction[SEL_W-1:0];
      dec.y2_sel = dec.c_sel;
      dec.write  = {dec.y2_sel != '0, dec.y1_sel != '0};
    end
  end

  assign bus.in_ready = (~out_valid_q | bus.out_ready) & ~hazard;
  assign accept       = bus.in_valid & bus.in_ready;
  assign issue        = accept & ~is_invalid;

`ifdef ALU_DEC_SCOREBOARD_EN
  logic [NREG-1:0] pending_q, pending_d, retired, busy, set_mask;

  always_comb begin
    retired = '0;
    if (bus.wb_valid[0]) retired[bus.wb_reg0] = 1'b1;
    if (bus.wb_valid[1]) retired[bus.wb_reg1] = 1'b1;
    busy    = pending_q & ~retired;
    busy[0] = 1'b0;
  end

  // Unused selects are 0 and busy[0] is never set, so they cannot cause a stall
  always_comb begin
    hazard = 1'b0;
    if (bus.in_valid && !is_invalid) begin
      hazard = busy[dec.a_sel] | busy[dec.b_sel] | busy[dec.c_sel] | busy[dec.d_sel]
             | (dec.write[0] & busy[dec.y1_sel]) | (dec.write[1] & busy[dec.y2_sel]);
    end
  end

  always_comb begin
    set_mask = '0;
    if (issue) begin
      if (dec.write[0]) set_mask[dec.y1_sel] = 1'b1;
      if (dec.write[1]) set_mask[dec.y2_sel] = 1'b1;
    end
    set_mask[0] = 1'b0;
    pending_d   = busy | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_valid, bus.wb_reg0, bus.wb_reg1};
  assign hazard    = 1'b0;
`endif

  always_comb begin
    bundle_d        = bundle_q;
    out_valid_d     = out_valid_q & ~bus.out_ready;
    if (issue) begin
      bundle_d    = dec;
      out_valid_d = 1'b1;
    end
    err_invalid_d   = accept & is_invalid;
    invalid_count_d = invalid_count_q;
    if (err_invalid_d && (invalid_count_q != '1)) invalid_count_d = invalid_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q        <= '0;
      out_valid_q     <= 1'b0;
      err_invalid_q   <= 1'b0;
      invalid_count_q <= '0;
    end else begin
      bundle_q        <= bundle_d;
      out_valid_q     <= out_valid_d;
      err_invalid_q   <= err_invalid_d;
      invalid_count_q <= invalid_count_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.alu_op        = bundle_q.op;
  assign bus.alu_form      = bundle_q.form;
  assign bus.alu_vec_perci = bundle_q.perci;
  assign bus.const_c       = bundle_q.const_c;
  assign bus.constant      = bundle_q.constant;
  assign bus.zero_reg      = bundle_q.zero_reg;
  assign bus.alu_a_select  = bundle_q.a_sel;
  assign bus.alu_b_select  = bundle_q.b_sel;
  assign bus.alu_c_select  = bundle_q.c_sel;
  assign bus.alu_d_select  = bundle_q.d_sel;
  assign bus.alu_y1_select = bundle_q.y1_sel;
  assign bus.alu_y2_select = bundle_q.y2_sel;
  assign bus.alu_write     = bundle_q.write;
  assign bus.err_invalid   = err_invalid_q;
  assign bus.invalid_count = invalid_count_q;
endmodule
